// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit helpers for the BCD arithmetic datapath.
package bcd_pkg;

    localparam int DIGIT_W  = 4;
    localparam int BCD_MAX  = 9;
    localparam int BCD_CORR = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bit offset of digit i inside a packed BCD vector.
    function automatic int digit_lsb(input int i);
        return i * DIGIT_W;
    endfunction

    function automatic logic [DIGIT_W-1:0] nines(input logic [DIGIT_W-1:0] d);
        return DIGIT_W'(BCD_MAX) - d;
    endfunction

    function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
        return d > DIGIT_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder: 4-bit ripple of full adders followed by the >9 decimal correction.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               cin,
    output logic [DIGIT_W-1:0] digit,
    output logic               cout
);

    logic [DIGIT_W:0]   c;
    logic [DIGIT_W-1:0] s;
    logic [DIGIT_W:0]   raw;
    logic [DIGIT_W-1:0] corr;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < DIGIT_W; gi++) begin : g_fa
            assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
            assign c[gi+1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign raw  = {c[DIGIT_W], s};
    assign cout = raw > (DIGIT_W+1)'(BCD_MAX);
    // raw - 10 modulo 16 equals s + 6, so the overflow bit can be dropped.
    assign corr  = s + DIGIT_W'(BCD_CORR);
    assign digit = cout ? corr : s;

endmodule

// File: rtl/bcd_serial_sub.sv
// Digit-serial BCD subtractor (A - B, LSD first) through one shared digit adder.
// Define BCD_SUB_SIGNMAG_EN to convert a negative result to sign-magnitude form.
module bcd_serial_sub
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   a,
    input  logic [4*NDIGITS-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NDIGITS-1:0]   diff,
    output logic                   borrow,
    output logic                   invalid
);

    localparam int W     = DIGIT_W * NDIGITS;
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NDIGITS - 1);

    state_t             state_reg, state_next;
    logic [W-1:0]       a_reg, b_reg, diff_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               carry_reg, borrow_reg, invalid_reg;

    logic [NDIGITS-1:0] bad_a, bad_b;
    logic               any_bad;
    logic [DIGIT_W-1:0] a_dig, b_dig, add_x, add_y, sum_dig;
    logic               sum_cout;

    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_chk
            assign bad_a[gi] = digit_bad(a[gi*DIGIT_W +: DIGIT_W]);
            assign bad_b[gi] = digit_bad(b[gi*DIGIT_W +: DIGIT_W]);
        end
    endgenerate

    assign any_bad = |{bad_a, bad_b};
    assign a_dig   = a_reg[digit_lsb(int'(idx_reg)) +: DIGIT_W];
    assign b_dig   = b_reg[digit_lsb(int'(idx_reg)) +: DIGIT_W];

`ifdef BCD_SUB_SIGNMAG_EN
    logic [DIGIT_W-1:0] d_dig;
    assign d_dig = diff_reg[digit_lsb(int'(idx_reg)) +: DIGIT_W];
`endif

    // In FIX the adder forms the ten's complement of the raw difference.
    always_comb begin
        add_x = a_dig;
        add_y = nines(b_dig);
`ifdef BCD_SUB_SIGNMAG_EN
        if (state_reg == FIX) begin
            add_x = '0;
            add_y = nines(d_dig);
        end
`endif
    end

    bcd_digit_add u_digit_add (
        .x     (add_x),
        .y     (add_y),
        .cin   (carry_reg),
        .digit (sum_dig),
        .cout  (sum_cout)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = any_bad ? DONE : SUB;
            SUB: begin
                if (idx_reg == LAST) begin
`ifdef BCD_SUB_SIGNMAG_EN
                    state_next = sum_cout ? DONE : FIX;
`else
                    state_next = DONE;
`endif
                end
            end
            FIX:     if (idx_reg == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            diff_reg    <= '0;
            idx_reg     <= '0;
            carry_reg   <= 1'b0;
            borrow_reg  <= 1'b0;
            invalid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg       <= a;
                        b_reg       <= b;
                        borrow_reg  <= 1'b0;
                        invalid_reg <= any_bad;
                        carry_reg   <= 1'b1;
                        idx_reg     <= '0;
                        if (any_bad) diff_reg <= '0;
                    end
                end
                SUB: begin
                    diff_reg[digit_lsb(int'(idx_reg)) +: DIGIT_W] <= sum_dig;
                    carry_reg <= sum_cout;
                    if (idx_reg == LAST) begin
                        borrow_reg <= ~sum_cout;
                        idx_reg    <= '0;
                        carry_reg  <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
`ifdef BCD_SUB_SIGNMAG_EN
                FIX: begin
                    diff_reg[digit_lsb(int'(idx_reg)) +: DIGIT_W] <= sum_dig;
                    carry_reg <= sum_cout;
                    idx_reg   <= (idx_reg == LAST) ? '0 : idx_reg + IDX_W'(1);
                end
`endif
                default: ;
            endcase
        end
    end

    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign diff    = diff_reg;
    assign borrow  = borrow_reg;
    assign invalid = invalid_reg;

endmodule
